// File: rtl/branch_resolve_if.sv
// -----------------------------------------------------------------------------
// branch_resolve_if
// Groups the branch-op handshake from the execute stage and the resolve results
// sent back to fetch and the younger pipeline stages.
//   in_valid/in_ready          : branch-op handshake (transfer when both high)
//   cmp_flags[3:0]             : comparator flags {Lt,Gt,Eq,Ne}
//   cond[2:0]                  : condition code (NONE,BEQ,BNE,BLT,BGT,BLE,BGE,JMP)
//   pc, offset [PC_W-1:0]      : branch PC and signed offset
//   redirect_valid/redirect_pc : one-cycle fetch redirect and its target
//   flush                      : kill younger stages
//   flag_err                   : one-cycle pulse on inconsistent flags
//   taken_count[CNT_W-1:0]     : saturating taken-branch counter
// master = upstream/observer side, slave = branch_resolve_unit.
// -----------------------------------------------------------------------------
interface branch_resolve_if #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       cmp_flags;
  logic [2:0]       cond;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  offset;
  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic             flush;
  logic             flag_err;
  logic [CNT_W-1:0] taken_count;

  modport master (
    output in_valid, cmp_flags, cond, pc, offset,
    input  in_ready, redirect_valid, redirect_pc, flush, flag_err, taken_count
  );

  modport slave (
    input  in_valid, cmp_flags, cond, pc, offset,
    output in_ready, redirect_valid, redirect_pc, flush, flag_err, taken_count
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
// Resolves a branch from the comparator flags and condition code. A taken branch
// produces a one-cycle redirect to fetch, then holds flush for FLUSH_CYCLES
// cycles. Inconsistent flags suppress the branch and pulse flag_err. A
// saturating counter tracks taken branches.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : branch_resolve_if.slave (handshake, operands and resolve outputs)
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int PC_W         = 8,
  parameter int FLUSH_CYCLES = 2,   // 1..15
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  branch_resolve_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RESOLVE, FLUSH} state_e;

  localparam logic [2:0] C_NONE = 3'd0;
  localparam logic [2:0] C_BEQ  = 3'd1;
  localparam logic [2:0] C_BNE  = 3'd2;
  localparam logic [2:0] C_BLT  = 3'd3;
  localparam logic [2:0] C_BGT  = 3'd4;
  localparam logic [2:0] C_BLE  = 3'd5;
  localparam logic [2:0] C_BGE  = 3'd6;
  localparam logic [2:0] C_JMP  = 3'd7;

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       flush_cnt_q, flush_cnt_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic             flag_err_q, flag_err_d;
  logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] taken_count_q, taken_count_d;

  logic lt, gt, eq, ne;
  logic flags_bad, cond_true, take, err, accept;

  assign {lt, gt, eq, ne} = bus.cmp_flags;
  assign accept = bus.in_valid && (state_q == IDLE);

  // Branch decision is made on the live operands at the transfer edge and
  // registered, so redirect/flag_err are clean flop outputs during RESOLVE.
  always_comb begin
    flags_bad = (eq == ne) || (lt && gt) || (eq && (lt || gt)) || (ne && !(lt || gt));
    unique case (bus.cond)
      C_NONE:  cond_true = 1'b0;
      C_BEQ:   cond_true = eq;
      C_BNE:   cond_true = ne;
      C_BLT:   cond_true = lt;
      C_BGT:   cond_true = gt;
      C_BLE:   cond_true = lt || eq;
      C_BGE:   cond_true = gt || eq;
      C_JMP:   cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
    // JMP does not look at the flags, so it can neither fail nor report them.
    take = (bus.cond == C_JMP) ? 1'b1 : (cond_true && !flags_bad);
    err  = (bus.cond != C_JMP) && flags_bad;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    state_d          = state_q;
    flush_cnt_d      = flush_cnt_q;
    redirect_valid_d = 1'b0;
    flag_err_d       = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    taken_count_d    = taken_count_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d          = RESOLVE;
          redirect_valid_d = take;
          flag_err_d       = err;
          if (take) begin
            // pc and offset share a width, so the two's-complement add is the
            // sign-extended sum already truncated to PC_W.
            redirect_pc_d = bus.pc + bus.offset;
            if (taken_count_q != '1) taken_count_d = taken_count_q + 1'b1;
          end
        end
      end
      RESOLVE: begin
        if (redirect_valid_q) begin
          state_d     = FLUSH;
          flush_cnt_d = FLUSH_LAST;
        end else begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        if (flush_cnt_q == 4'd0) state_d = IDLE;
        else                     flush_cnt_d = flush_cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      state_q          <= IDLE;
      flush_cnt_q      <= '0;
      redirect_valid_q <= 1'b0;
      flag_err_q       <= 1'b0;
      redirect_pc_q    <= '0;
      taken_count_q    <= '0;
    end else begin
      state_q          <= state_d;
      flush_cnt_q      <= flush_cnt_d;
      redirect_valid_q <= redirect_valid_d;
      flag_err_q       <= flag_err_d;
      redirect_pc_q    <= redirect_pc_d;
      taken_count_q    <= taken_count_d;
    end
  end

  assign bus.in_ready       = (state_q == IDLE);
  assign bus.flush          = (state_q == FLUSH);
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flag_err       = flag_err_q;
  assign bus.taken_count    = taken_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
// Directed bench: each branch op pushes its expected outcome into a scoreboard
// queue when driven; the entry is popped and compared in the RESOLVE cycle.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;
  localparam int PC_W = 8;
  localparam int CNT_W = 8;
  localparam int FLUSH_CYCLES = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_resolve_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  branch_resolve_unit #(
    .PC_W(PC_W), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       taken;
    logic       err;
    logic [7:0] pc;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passes = 0;
  int   fails  = 0;
  int   exp_count = 0;
  logic [7:0] exp_pc = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent reference: decide taken/err straight from the condition table.
  function automatic exp_t model(input logic [2:0] c, input logic [3:0] f,
                                 input logic [7:0] p, input logic [7:0] o);
    exp_t r;
    logic bad, hit;
    bad = (f[1] == f[0]) || (f[3] && f[2]) || (f[1] && (f[3] || f[2])) ||
          (f[0] && !(f[3] || f[2]));
    case (c)
      3'd1: hit = f[1];
      3'd2: hit = f[0];
      3'd3: hit = f[3];
      3'd4: hit = f[2];
      3'd5: hit = f[3] | f[1];
      3'd6: hit = f[2] | f[1];
      default: hit = 1'b0;
    endcase
    r.taken = (c == 3'd7) ? 1'b1 : (hit && !bad);
    r.err   = (c != 3'd7) && bad;
    r.pc    = 8'((p + o) & 8'hFF);
    return r;
  endfunction

  task automatic drive(input logic [2:0] c, input logic [3:0] f,
                       input logic [7:0] p, input logic [7:0] o);
    bus.in_valid  = 1'b1;
    bus.cond      = c;
    bus.cmp_flags = f;
    bus.pc        = p;
    bus.offset    = o;
    sb.push_back(model(c, f, p, o));
  endtask

  // Called at the negedge inside RESOLVE: pop and compare.
  task automatic check_resolve(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    if (e.taken) begin
      exp_pc = e.pc;
      if (exp_count < 255) exp_count++;
    end
    check({tag, "_redirect_valid"}, 32'(bus.redirect_valid), 32'(e.taken));
    check({tag, "_redirect_pc"},    32'(bus.redirect_pc),    32'(exp_pc));
    check({tag, "_flag_err"},       32'(bus.flag_err),       32'(e.err));
    check({tag, "_in_ready"},       32'(bus.in_ready),       32'd0);
    check({tag, "_taken_count"},    32'(bus.taken_count),    32'(exp_count));
  endtask

  // One complete op starting and ending at a negedge with the unit idle.
  task automatic op(input string tag, input logic [2:0] c, input logic [3:0] f,
                    input logic [7:0] p, input logic [7:0] o);
    int budget;
    logic tk;
    budget = 20;
    drive(c, f, p, o);
    tk = sb[$].taken;
    while (!bus.in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      check({tag, "_ready_timeout"}, 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      void'(sb.pop_back());
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_resolve(tag);
    if (tk) begin
      for (int i = 0; i < FLUSH_CYCLES; i++) begin
        @(negedge clk);
        check({tag, "_flush_hi"},     32'(bus.flush),          32'd1);
        check({tag, "_flush_ready"},  32'(bus.in_ready),       32'd0);
        check({tag, "_flush_redir"},  32'(bus.redirect_valid), 32'd0);
      end
    end
    @(negedge clk);
    check({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_idle_flush"}, 32'(bus.flush),    32'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.cond      = 3'd0;
    bus.cmp_flags = 4'd0;
    bus.pc        = 8'd0;
    bus.offset    = 8'd0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready",    32'(bus.in_ready),       32'd1);
    check("rst_redirect",    32'(bus.redirect_valid), 32'd0);
    check("rst_redirect_pc", 32'(bus.redirect_pc),    32'd0);
    check("rst_flush",       32'(bus.flush),          32'd0);
    check("rst_flag_err",    32'(bus.flag_err),       32'd0);
    check("rst_count",       32'(bus.taken_count),    32'd0);
    rst = 1'b0;
    @(negedge clk);

    op("beq_taken",   3'd1, 4'b0010, 8'h10, 8'h05);
    op("blt_not",     3'd3, 4'b0101, 8'h20, 8'h07);
    op("bge_wrap",    3'd6, 4'b0010, 8'hFE, 8'h04);
    op("bne_neg",     3'd2, 4'b1001, 8'h03, 8'hFA);
    op("beq_bad",     3'd1, 4'b0011, 8'h40, 8'h01);
    op("jmp_badflag", 3'd7, 4'b1100, 8'h50, 8'h10);
    op("ble_lt",      3'd5, 4'b1001, 8'h60, 8'h80);
    op("bgt_not",     3'd4, 4'b1001, 8'h70, 8'h01);
    op("none",        3'd0, 4'b0010, 8'h80, 8'h01);
    op("bgt_bad",     3'd4, 4'b0110, 8'h90, 8'h01);

    // in_valid held across a taken branch: second op waits for the flush.
    drive(3'd7, 4'b0000, 8'h20, 8'h10);
    @(posedge clk);
    @(negedge clk);
    check_resolve("hold_a");
    drive(3'd1, 4'b0010, 8'hA0, 8'h0F);   // in_valid stays high
    for (int i = 0; i < FLUSH_CYCLES; i++) begin
      @(negedge clk);
      check("hold_flush_hi",    32'(bus.flush),    32'd1);
      check("hold_not_ready",   32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    check("hold_ready_after", 32'(bus.in_ready), 32'd1);
    check("hold_no_flush",    32'(bus.flush),    32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_resolve("hold_b");
    @(negedge clk);
    check("rstflush_first", 32'(bus.flush), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_count = 0;
    exp_pc    = 8'h00;
    check("rstflush_flush", 32'(bus.flush),          32'd0);
    check("rstflush_ready", 32'(bus.in_ready),       32'd1);
    check("rstflush_count", 32'(bus.taken_count),    32'd0);
    check("rstflush_redir", 32'(bus.redirect_valid), 32'd0);
    @(negedge clk);
    check("rstflush_stay",  32'(bus.flush),          32'd0);

    // Saturation of the taken counter.
    for (int i = 0; i < 300; i++) begin
      op("jmp_sat", 3'd7, 4'b0000, 8'(i), 8'h01);
    end
    check("sat_count_final", 32'(bus.taken_count), 32'hFF);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Sits directly downstream of the 8-bit operand comparator in the pipelined CPU's execute stage.
- Consumes the 4-bit comparison flags {Lt,Gt,Eq,Ne} together with a branch condition code, PC and offset. Decides whether the branch is taken.
- On a taken branch, issues a one-cycle PC redirect to fetch and holds a flush to younger stages for a fixed number of cycles.
- Keeps a saturating count of taken branches for performance debug.

Parameters:
- PC_W, 8, width of PC, offset and redirect target.
- FLUSH_CYCLES, 2, number of cycles flush is held after a redirect (legal range 1..15).
- CNT_W, 8, width of the taken-branch counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream presents a branch op this cycle.
- in_ready  out  1  unit can accept a branch op.
- cmp_flags  in  4  comparator output {Lt,Gt,Eq,Ne}; bit3=Lt, bit2=Gt, bit1=Eq, bit0=Ne.
- cond  in  3  condition code: 0 NONE, 1 BEQ, 2 BNE, 3 BLT, 4 BGT, 5 BLE, 6 BGE, 7 JMP.
- pc  in  PC_W  PC of the branch instruction.
- offset  in  PC_W  signed two's-complement branch offset.
- redirect_valid  out  1  one-cycle pulse: fetch must load redirect_pc.
- redirect_pc  out  PC_W  branch target.
- flush  out  1  kill younger pipeline stages.
- flag_err  out  1  one-cycle pulse: inconsistent flags received.
- taken_count  out  CNT_W  saturating count of taken branches.

Behaviour:
- Reset: rst is synchronous and active-high. When asserted on a clk edge:
  - state = IDLE, in_ready = 1.
  - redirect_valid = 0, redirect_pc = 0, flush = 0, flag_err = 0, taken_count = 0.
  - Flush counter and captured registers are cleared.
  - Reset mid-RESOLVE or mid-FLUSH aborts immediately: no redirect and no further flush cycles.
- States: IDLE, RESOLVE, FLUSH.
- IDLE:
  - in_ready = 1.
  - A transfer occurs when in_valid && in_ready. It captures cmp_flags, cond, pc and offset, then moves to RESOLVE.
  - If in_valid = 0, stay in IDLE.
- RESOLVE (exactly one cycle, in_ready = 0):
  - Compute taken:
    - BEQ = Eq; BNE = Ne; BLT = Lt; BGT = Gt.
    - BLE = Lt|Eq; BGE = Gt|Eq.
    - JMP = 1; NONE = 0.
  - Flags are inconsistent if any of these hold: Eq==Ne, Lt&Gt, Eq&(Lt|Gt), or Ne&!(Lt|Gt).
    - Inconsistent flags force taken = 0 and pulse flag_err in this cycle.
    - JMP ignores the flags, so it never raises flag_err.
  - If taken:
    - redirect_valid = 1 for this cycle only.
    - redirect_pc = pc + sign-extended offset, truncated to PC_W (wraps mod 2^PC_W).
    - taken_count increments, saturating at all-ones.
    - Next state is FLUSH.
  - If not taken: redirect_valid stays 0 and the next state is IDLE.
- Latency: a transfer at edge T gives resolve outputs valid during the cycle after T. flush first appears in the following cycle.
- FLUSH:
  - flush = 1 and in_ready = 0 for exactly FLUSH_CYCLES consecutive cycles, then return to IDLE.
  - Any in_valid presented during this time is not accepted. Upstream must hold it.
- Outputs registered vs combinational:
  - redirect_valid, redirect_pc and flag_err are registered state-decoded outputs, asserted only while the FSM is in RESOLVE.
  - redirect_pc holds its last value when redirect_valid = 0.
- Throughput:
  - Back-to-back not-taken ops: one op every 2 cycles (IDLE, RESOLVE).
  - Taken op: 2 + FLUSH_CYCLES cycles.

Test Plan:
- Reset, then BEQ, flags 4'b0010, pc=8'h10, offset=8'h05 -> RESOLVE cycle has redirect_valid=1 and redirect_pc=8'h15. Then flush=1 for 2 cycles, in_ready=0 for 3 cycles, taken_count=1.
- BLT, flags 4'b0101 (Gt,Ne) -> not taken: redirect_valid=0, flush never asserted, in_ready returns 1 the cycle after RESOLVE, taken_count unchanged.
- Wrap-around: BGE, flags 4'b0010, pc=8'hFE, offset=8'h04 -> redirect_pc=8'h02. Negative offset: BNE, flags 4'b1001, pc=8'h03, offset=8'hFA -> redirect_pc=8'hFD.
- Inconsistent flags: BEQ with 4'b0011 -> flag_err pulse, no redirect. JMP with 4'b1100 -> taken, flag_err=0.
- in_valid held high across a taken branch with FLUSH_CYCLES=2 -> second op accepted only after flush deasserts. Assert rst during the first FLUSH cycle -> flush=0 the next cycle, in_ready=1, taken_count=0.
- 300 consecutive JMPs with CNT_W=8 -> taken_count saturates at 8'hFF and stays there.
